// File: rtl/viterbi_ber_checker.sv
// Aligns encoder source bits to Viterbi decoder output through a FIFO and scores mismatches, bursts and windowed sync.
// Results appear one cycle after dec_valid_i; the decoder is never stalled, and FIFO over/underflow latches FAULT.
module viterbi_ber_checker #(
  parameter int AW     = 6,
  parameter int SKIP   = 16,
  parameter int WIN    = 256,
  parameter int THRESH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          src_valid_i,
  input  logic          src_bit_i,
  input  logic          dec_valid_i,
  input  logic          dec_bit_i,
  output logic [31:0]   bit_ct_o,
  output logic [31:0]   err_ct_o,
  output logic [7:0]    burst_max_o,
  output logic          sync_ok_o,
  output logic          fault_o,
  output logic [AW:0]   level_o,
  output logic [1:0]    state_o
);

  localparam int DEPTH = 1 << AW;
  localparam int SW    = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int WW    = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    TRACK  = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [AW:0]   level_q, level_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [WW-1:0] win_bits_q, win_bits_d, win_errs_q, win_errs_d, win_errs_nx;
  logic [31:0]   bit_ct_q, bit_ct_d, err_ct_q, err_ct_d;
  logic [7:0]    run_q, run_d, burst_q, burst_d;
  logic          sync_q, sync_d, fault_q, fault_d;
  logic          we, active, full, empty, push, pop, head, mism;

  assign active      = (state_q == WARMUP) || (state_q == TRACK);
  assign push        = src_valid_i;
  assign pop         = dec_valid_i;
  assign full        = (level_q == (AW+1)'(DEPTH));
  assign empty       = (level_q == '0);
  // An empty FIFO with a simultaneous push hands the new bit straight to the compare.
  assign head        = empty ? src_bit_i : mem_q[rd_ptr_q];
  assign mism        = head ^ dec_bit_i;
  assign win_errs_nx = win_errs_q + WW'(mism);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    skip_d     = skip_q;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    bit_ct_d   = bit_ct_q;
    err_ct_d   = err_ct_q;
    run_d      = run_q;
    burst_d    = burst_q;
    sync_d     = sync_q;
    fault_d    = fault_q;
    we         = 1'b0;
    wr_addr    = wr_ptr_q;

    if (start_i) begin
      state_d    = (SKIP == 0) ? TRACK : WARMUP;
      we         = src_valid_i;
      wr_addr    = '0;
      wr_ptr_d   = AW'(src_valid_i);
      rd_ptr_d   = '0;
      level_d    = (AW+1)'(src_valid_i);
      skip_d     = '0;
      win_bits_d = '0;
      win_errs_d = '0;
      bit_ct_d   = '0;
      err_ct_d   = '0;
      run_d      = '0;
      burst_d    = '0;
      sync_d     = 1'b0;
      fault_d    = 1'b0;
    end else if (active) begin
      if ((push && !pop && full) || (pop && !push && empty)) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else begin
        if (push) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);

        if (pop && state_q == WARMUP) begin
          skip_d = skip_q + SW'(1);
          if (int'(skip_q) == SKIP - 1) state_d = TRACK;
        end

        if (pop && state_q == TRACK) begin
          bit_ct_d = (bit_ct_q == '1) ? bit_ct_q : bit_ct_q + 32'd1;
          if (mism && err_ct_q != '1) err_ct_d = err_ct_q + 32'd1;
          run_d   = mism ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : 8'd0;
          burst_d = (run_d > burst_q) ? run_d : burst_q;
          if (int'(win_bits_q) == WIN - 1) begin
            sync_d     = (int'(win_errs_nx) <= THRESH);
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WW'(1);
            win_errs_d = win_errs_nx;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      skip_q     <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      bit_ct_q   <= '0;
      err_ct_q   <= '0;
      run_q      <= '0;
      burst_q    <= '0;
      sync_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      skip_q     <= skip_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      bit_ct_q   <= bit_ct_d;
      err_ct_q   <= err_ct_d;
      run_q      <= run_d;
      burst_q    <= burst_d;
      sync_q     <= sync_d;
      fault_q    <= fault_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= src_bit_i;
  end

  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign burst_max_o = burst_q;
  assign sync_ok_o   = sync_q;
  assign fault_o     = fault_q;
  assign level_o     = level_q;
  assign state_o     = state_q;

endmodule
